alu_ctrl: RTL and testbench

Sequencing front end for the 8-bit combinational `alu`: accepts 16-bit instruction words over a valid/ready handshake, reads operands from a 4×8 register file, drives the ALU's `opcode`/`a`/`b`, and captures and writes back the ALU result. It is the issuing side of the ALU interface. The `alu` instance sits outside this block, with its ports wired to `alu_op`, `alu_a`, `alu_b` and `alu_result`.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_regfile.sv | 46 ++++
 rtl/alu_ctrl.sv | 164 ++++++++++++++++
 tb/tb_alu_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its sequencing front end (alu_ctrl):
// opcode constants, controller state encoding and instruction field positions.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int INSTR_W = 16;
    localparam int REG_AW = 2;

    localparam logic [2:0] OP_PLUS    = 3'd0;
    localparam logic [2:0] OP_MINUS   = 3'd1;
    localparam logic [2:0] OP_BAND    = 3'd2;
    localparam logic [2:0] OP_BOR     = 3'd3;
    localparam logic [2:0] OP_UNEGATE = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2
    } state_t;

    // Instruction word layout: op | rd | ra | imm_sel | imm (rb lives in imm[7:6])
    localparam int OP_MSB      = 15;
    localparam int OP_LSB      = 13;
    localparam int RD_MSB      = 12;
    localparam int RD_LSB      = 11;
    localparam int RA_MSB      = 10;
    localparam int RA_LSB      = 9;
    localparam int IMM_SEL_BIT = 8;
    localparam int IMM_MSB     = 7;
    localparam int IMM_LSB     = 0;
    localparam int RB_MSB      = 7;
    localparam int RB_LSB      = 6;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_UNEGATE;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for alu_ctrl: NREGS x DW storage, two combinational read ports,
// one synchronous write port; r0 reads as zero and ignores writes.
module alu_regfile #(
    parameter int NREGS = 4,
    parameter int DW    = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem_q [NREGS];
    logic [DW-1:0] mem_d [NREGS];

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we && (waddr != '0)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem_q[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem_q[raddr_b];

endmodule

// File: rtl/alu_ctrl.sv
// Issuing front end for the external combinational alu: accepts instructions,
// drives alu_op/alu_a/alu_b, retires and writes back results. Optional perf
// counter enabled by defining ALU_CTRL_PERF_EN.
module alu_ctrl #(
    parameter int NREGS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_result,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic        res_err
`ifdef ALU_CTRL_PERF_EN
    ,
    output logic [15:0] perf_count
`endif
);
    import alu_pkg::*;

    state_t              state_q, state_d;
    logic                instr_ready_q, instr_ready_d;
    logic                res_valid_q, res_valid_d;
    logic [2:0]          alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic                res_err_q, res_err_d;

    logic                handshake;
    logic                rf_we;
    logic [REG_AW-1:0]   ra_field, rb_field;
    logic [DATA_W-1:0]   rf_rdata_a, rf_rdata_b;
    logic [DATA_W-1:0]   operand_b;

    assign ra_field  = instr[RA_MSB:RA_LSB];
    assign rb_field  = instr[RB_MSB:RB_LSB];
    assign handshake = instr_valid && instr_ready_q;
    assign operand_b = instr[IMM_SEL_BIT] ? instr[IMM_MSB:IMM_LSB] : rf_rdata_b;

    alu_regfile #(
        .NREGS (NREGS),
        .DW    (DATA_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rd_q),
        .wdata   (alu_result),
        .raddr_a (ra_field),
        .raddr_b (rb_field),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b)
    );

    always_comb begin
        state_d    = state_q;
        alu_op_d   = alu_op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        rd_d       = rd_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        rf_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WB;
                // Illegal opcodes leave the ALU output undefined, so report zero.
                if (op_is_legal(alu_op_q)) begin
                    res_data_d = alu_result;
                    res_err_d  = 1'b0;
                    rf_we      = 1'b1;
                end else begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                end
            end
            ST_WB: begin
                state_d = handshake ? ST_ISSUE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // In WB the register file already holds the just-retired result.
        if (handshake) begin
            alu_op_d = instr[OP_MSB:OP_LSB];
            alu_a_d  = rf_rdata_a;
            alu_b_d  = operand_b;
            rd_d     = instr[RD_MSB:RD_LSB];
        end

        instr_ready_d = (state_d != ST_ISSUE);
        res_valid_d   = (state_d == ST_WB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            instr_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            alu_op_q      <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            rd_q          <= '0;
            res_data_q    <= '0;
            res_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_ready_q <= instr_ready_d;
            res_valid_q   <= res_valid_d;
            alu_op_q      <= alu_op_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            rd_q          <= rd_d;
            res_data_q    <= res_data_d;
            res_err_q     <= res_err_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign res_valid   = res_valid_q;
    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign res_data    = res_data_q;
    assign res_err     = res_err_q;

`ifdef ALU_CTRL_PERF_EN
    logic [15:0] perf_count_q, perf_count_d;

    // Counts successful retirements, saturating rather than wrapping.
    always_comb begin
        perf_count_d = perf_count_q;
        if (res_valid_q && !res_err_q && (perf_count_q != 16'hFFFF)) begin
            perf_count_d = perf_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_count_q <= '0;
        end else begin
            perf_count_q <= perf_count_d;
        end
    end

    assign perf_count = perf_count_q;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl with a behavioural ALU attached to its issue port.
`timescale 1ns/1ps
module tb_alu_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_result;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_err;
`ifdef ALU_CTRL_PERF_EN
    logic [15:0] perf_count;
`endif

    alu_ctrl #(.NREGS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_err     (res_err)
`ifdef ALU_CTRL_PERF_EN
        ,
        .perf_count  (perf_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural ALU; illegal opcodes yield junk that must never be retired.
    always_comb begin
        case (alu_op)
            OP_PLUS:    alu_result = alu_a + alu_b;
            OP_MINUS:   alu_result = alu_a - alu_b;
            OP_BAND:    alu_result = alu_a & alu_b;
            OP_BOR:     alu_result = alu_a | alu_b;
            OP_UNEGATE: alu_result = ~alu_a;
            default:    alu_result = 8'hA5;
        endcase
    end

    typedef struct {
        string      tag;
        logic [7:0] data;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   pos_cyc = 0;
    int   exp_perf = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] ra, input logic isel,
                                        input logic [7:0] low);
        return {op, rd, ra, isel, low};
    endfunction

    always @(posedge clk) pos_cyc++;

    // Retirement monitor: pops one expectation per res_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && res_valid) begin
            if (sb.size() == 0) begin
                check("spurious_res_valid", 16'd1, 16'd0);
            end else begin
                e = sb.pop_front();
                $display("retire %s data=%h err=%b", e.tag, res_data, res_err);
                check({e.tag, "_data"}, {8'h00, res_data}, {8'h00, e.data});
                check({e.tag, "_err"}, {15'd0, res_err}, {15'd0, e.err});
                check({e.tag, "_latency"}, 16'(pos_cyc - e.cyc), 16'd2);
                check({e.tag, "_ready_in_wb"}, {15'd0, instr_ready}, 16'd1);
                if (!e.err) exp_perf++;
            end
        end
    end

    task automatic send(input string tag, input logic [15:0] w, input logic keep,
                        input logic expect_res, input logic [7:0] ed, input logic ee,
                        output int waits);
        int  n;
        bit  ok;
        n = 0;
        ok = 1'b0;
        instr_valid = 1'b1;
        instr = w;
        while (n < 20 && !ok) begin
            @(negedge clk);
            n++;
            if (instr_ready) ok = 1'b1;
        end
        waits = n;
        if (!ok) begin
            check({tag, "_accept_timeout"}, 16'd0, 16'd1);
            instr_valid = 1'b0;
            return;
        end
        if (expect_res) sb.push_back('{tag: tag, data: ed, err: ee, cyc: pos_cyc});
        @(posedge clk);
        #1;
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 20 && sb.size() != 0) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 16'(sb.size()), 16'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr_ready"}, {15'd0, instr_ready}, 16'd1);
        check({tag, "_alu_op"}, {13'd0, alu_op}, 16'd0);
        check({tag, "_alu_a"}, {8'd0, alu_a}, 16'd0);
        check({tag, "_alu_b"}, {8'd0, alu_b}, 16'd0);
        check({tag, "_res_valid"}, {15'd0, res_valid}, 16'd0);
        check({tag, "_res_data"}, {8'd0, res_data}, 16'd0);
        check({tag, "_res_err"}, {15'd0, res_err}, 16'd0);
`ifdef ALU_CTRL_PERF_EN
        check({tag, "_perf_count"}, perf_count, 16'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w1, w2, wd;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load and read back
        send("bor_r1_2a",   enc(OP_BOR,  2'd1, 2'd0, 1'b1, 8'h2A), 1'b0, 1'b1, 8'h2A, 1'b0, wd);
        send("plus_r2_r1",  enc(OP_PLUS, 2'd2, 2'd1, 1'b1, 8'h00), 1'b0, 1'b1, 8'h2A, 1'b0, wd);
        // Modulo-256 wrap
        send("bor_r1_ff",   enc(OP_BOR,  2'd1, 2'd0, 1'b1, 8'hFF), 1'b0, 1'b1, 8'hFF, 1'b0, wd);
        send("plus_wrap",   enc(OP_PLUS, 2'd3, 2'd1, 1'b1, 8'h01), 1'b0, 1'b1, 8'h00, 1'b0, wd);
        send("bor_r1_01",   enc(OP_BOR,  2'd1, 2'd0, 1'b1, 8'h01), 1'b0, 1'b1, 8'h01, 1'b0, wd);
        send("minus_wrap",  enc(OP_MINUS,2'd3, 2'd1, 1'b1, 8'h02), 1'b0, 1'b1, 8'hFF, 1'b0, wd);
        // Bitwise and unary, register-sourced b
        send("bor_r1_f0",   enc(OP_BOR,  2'd1, 2'd0, 1'b1, 8'hF0), 1'b0, 1'b1, 8'hF0, 1'b0, wd);
        send("bor_r2_3c",   enc(OP_BOR,  2'd2, 2'd0, 1'b1, 8'h3C), 1'b0, 1'b1, 8'h3C, 1'b0, wd);
        send("band_r1_r2",  enc(OP_BAND, 2'd3, 2'd1, 1'b0, {2'd2, 6'd0}), 1'b0, 1'b1, 8'h30, 1'b0, wd);
        send("bor_r1_r2",   enc(OP_BOR,  2'd3, 2'd1, 1'b0, {2'd2, 6'd0}), 1'b0, 1'b1, 8'hFC, 1'b0, wd);
        send("unegate_r1",  enc(OP_UNEGATE, 2'd3, 2'd1, 1'b0, 8'h00), 1'b0, 1'b1, 8'h0F, 1'b0, wd);
        // Illegal opcodes: error, zero data, no write
        send("illegal_6",   enc(3'd6, 2'd1, 2'd2, 1'b1, 8'h11), 1'b0, 1'b1, 8'h00, 1'b1, wd);
        send("illegal_5",   enc(3'd5, 2'd2, 2'd1, 1'b1, 8'h22), 1'b0, 1'b1, 8'h00, 1'b1, wd);
        send("illegal_7",   enc(3'd7, 2'd3, 2'd1, 1'b0, 8'h00), 1'b0, 1'b1, 8'h00, 1'b1, wd);
        send("rd_r1_after", enc(OP_PLUS, 2'd3, 2'd1, 1'b1, 8'h00), 1'b0, 1'b1, 8'hF0, 1'b0, wd);
        send("rd_r2_after", enc(OP_PLUS, 2'd3, 2'd2, 1'b1, 8'h00), 1'b0, 1'b1, 8'h3C, 1'b0, wd);
        send("minus_r2_r1", enc(OP_MINUS,2'd3, 2'd2, 1'b0, {2'd1, 6'd0}), 1'b0, 1'b1, 8'h4C, 1'b0, wd);
        check("issue_alu_op", {13'd0, alu_op}, {13'd0, OP_MINUS});
        check("issue_alu_a", {8'd0, alu_a}, 16'h003C);
        check("issue_alu_b", {8'd0, alu_b}, 16'h00F0);
        drain();

        // Back-to-back with a dependency through r1
        send("b2b_bor_r1",  enc(OP_BOR,  2'd1, 2'd0, 1'b1, 8'h05), 1'b1, 1'b1, 8'h05, 1'b0, w1);
        send("b2b_plus",    enc(OP_PLUS, 2'd2, 2'd1, 1'b0, {2'd1, 6'd0}), 1'b0, 1'b1, 8'h0A, 1'b0, w2);
        check("b2b_first_wait", 16'(w1), 16'd1);
        check("b2b_second_wait", 16'(w2), 16'd2);

        // r0 writes are reported but discarded
        send("bor_r0_7",    enc(OP_BOR,  2'd0, 2'd0, 1'b1, 8'h07), 1'b0, 1'b1, 8'h07, 1'b0, wd);
        send("rd_r0",       enc(OP_PLUS, 2'd3, 2'd0, 1'b1, 8'h00), 1'b0, 1'b1, 8'h00, 1'b0, wd);
        send("rd_r2_b2b",   enc(OP_PLUS, 2'd3, 2'd2, 1'b1, 8'h00), 1'b0, 1'b1, 8'h0A, 1'b0, wd);
        drain();
`ifdef ALU_CTRL_PERF_EN
        check("perf_count", perf_count, 16'(exp_perf));
`endif

        // Reset during ISSUE aborts the instruction
        send("abort",       enc(OP_BOR,  2'd1, 2'd0, 1'b1, 8'h55), 1'b0, 1'b0, 8'h00, 1'b0, wd);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_reset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_perf = 0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_res_valid", {15'd0, res_valid}, 16'd0);
        send("rd_r1_cleared", enc(OP_PLUS, 2'd3, 2'd1, 1'b1, 8'h00), 1'b0, 1'b1, 8'h00, 1'b0, wd);
        drain();
`ifdef ALU_CTRL_PERF_EN
        check("perf_count_final", perf_count, 16'(exp_perf));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
